// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Module   : y86_pkg
// Purpose  : Shared Y86-64 definitions used by the fetch stage and the
//            sequential controller: instruction codes, status codes, the
//            sequencer state encoding and the memory-op classifier.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package y86_pkg;

  // Instruction codes (upper nibble of the first instruction byte)
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Processor status codes
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_PCUPD  = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  // True for instructions that perform a data-memory access in MEM
  function automatic logic is_mem_op(input logic [3:0] icode);
    case (icode)
      I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: return 1'b1;
      default:                                           return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/y86_next_pc.sv
`default_nettype none
// ============================================================================
// Module   : y86_next_pc
// Purpose  : Combinational next-PC selection for the sequential Y86-64 core.
// Ports    : icode   [3:0]  - instruction code of the retiring instruction
//            cnd            - branch condition sampled after execute
//            valC    [63:0] - constant word (jump / call target)
//            valM_q  [63:0] - memory read data captured at ack (ret target)
//            valP    [63:0] - address of the following instruction
//            next_pc [63:0] - selected next PC
// Revision : 1.0 - initial release
// ============================================================================
module y86_next_pc (
  input  logic [3:0]  icode,
  input  logic        cnd,
  input  logic [63:0] valC,
  input  logic [63:0] valM_q,
  input  logic [63:0] valP,
  output logic [63:0] next_pc
);
  import y86_pkg::*;

  always_comb begin
    next_pc = valP;
    if (icode == I_CALL || (icode == I_JXX && cnd))
      next_pc = valC;
    else if (icode == I_RET)
      next_pc = valM_q;
  end

endmodule
`default_nettype wire

// File: rtl/y86_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : y86_seq_ctrl
// Purpose  : Multi-cycle sequencer for the sequential Y86-64 core. Owns the
//            PC, pulses one stage enable per cycle through F/D/E/M/W/PC-update,
//            runs the data-memory req/ack handshake with a timeout and tracks
//            the processor status, stopping on any non-AOK status.
// Ports    : clk, rst_n (async active-low)
//            start                       - leave IDLE and run from pc
//            icode, instr_valid, imem_error, valC, valP - fetch results
//            cnd                         - execute condition
//            valM, dmem_ack, dmem_error  - data-memory response
//            pc                          - current instruction address
//            fetch_en..wb_en             - one-hot stage strobes
//            dmem_req                    - data-memory request
//            stat, halted                - processor status
//            instr_cnt, cycle_cnt        - retired / active-cycle counters
// Revision : 1.0 - initial release
// ============================================================================
module y86_seq_ctrl #(
  parameter logic [63:0] RESET_PC    = 64'd0,
  parameter logic [63:0] IMEM_MAX    = 64'd1023,
  parameter int          MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic        instr_valid,
  input  logic        imem_error,
  input  logic [63:0] valC,
  input  logic [63:0] valP,
  input  logic        cnd,
  input  logic [63:0] valM,
  input  logic        dmem_ack,
  input  logic        dmem_error,
  output logic [63:0] pc,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        exec_en,
  output logic        mem_en,
  output logic        wb_en,
  output logic        dmem_req,
  output logic [2:0]  stat,
  output logic        halted,
  output logic [31:0] instr_cnt,
  output logic [31:0] cycle_cnt
);
  import y86_pkg::*;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            r_state;
  logic [3:0]        r_icode;
  logic [63:0]       r_valC;
  logic [63:0]       r_valP;
  logic [63:0]       r_valM;
  logic              r_cnd;
  logic [WAIT_W-1:0] r_wait;
  logic [63:0]       w_next_pc;

  y86_next_pc u_next_pc (
    .icode   (r_icode),
    .cnd     (r_cnd),
    .valC    (r_valC),
    .valM_q  (r_valM),
    .valP    (r_valP),
    .next_pc (w_next_pc)
  );

  // Enables are registered: each transition raises the strobe belonging to
  // the state being entered, so strobes line up exactly with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      pc        <= RESET_PC;
      fetch_en  <= 1'b0;
      decode_en <= 1'b0;
      exec_en   <= 1'b0;
      mem_en    <= 1'b0;
      wb_en     <= 1'b0;
      dmem_req  <= 1'b0;
      stat      <= STAT_AOK;
      halted    <= 1'b0;
      instr_cnt <= 32'd0;
      cycle_cnt <= 32'd0;
      r_icode   <= I_HALT;
      r_valC    <= 64'd0;
      r_valP    <= 64'd0;
      r_valM    <= 64'd0;
      r_cnd     <= 1'b0;
      r_wait    <= '0;
    end else begin
      fetch_en  <= 1'b0;
      decode_en <= 1'b0;
      exec_en   <= 1'b0;
      mem_en    <= 1'b0;
      wb_en     <= 1'b0;

      if (r_state != S_IDLE && r_state != S_HALT)
        cycle_cnt <= cycle_cnt + 32'd1;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_FETCH;
            fetch_en <= 1'b1;
          end
        end

        S_FETCH: begin
          r_state   <= S_DECODE;
          decode_en <= 1'b1;
        end

        S_DECODE: begin
          // Fetch results are stable by the end of DECODE; latch them here.
          r_icode <= icode;
          r_valC  <= valC;
          r_valP  <= valP;
          if (imem_error || pc > IMEM_MAX) begin
            stat    <= STAT_ADR;
            halted  <= 1'b1;
            r_state <= S_HALT;
          end else if (!instr_valid) begin
            stat    <= STAT_INS;
            halted  <= 1'b1;
            r_state <= S_HALT;
          end else if (icode == I_HALT) begin
            stat    <= STAT_HLT;
            halted  <= 1'b1;
            r_state <= S_HALT;
          end else begin
            r_state <= S_EXEC;
            exec_en <= 1'b1;
          end
        end

        S_EXEC: begin
          r_cnd    <= cnd;
          r_wait   <= '0;
          r_state  <= S_MEM;
          mem_en   <= 1'b1;
          dmem_req <= is_mem_op(r_icode);
        end

        S_MEM: begin
          if (!dmem_req) begin
            // Non-memory instruction: single pass-through cycle
            r_state <= S_WB;
            wb_en   <= 1'b1;
          end else if (dmem_ack) begin
            dmem_req <= 1'b0;
            r_valM   <= valM;
            if (dmem_error) begin
              stat    <= STAT_ADR;
              halted  <= 1'b1;
              r_state <= S_HALT;
            end else begin
              r_state <= S_WB;
              wb_en   <= 1'b1;
            end
          end else if (r_wait == WAIT_W'(MEM_TIMEOUT - 1)) begin
            // This was the last allowed wait cycle without an ack
            dmem_req <= 1'b0;
            stat     <= STAT_ADR;
            halted   <= 1'b1;
            r_state  <= S_HALT;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
            mem_en <= 1'b1;
          end
        end

        S_WB: begin
          r_state <= S_PCUPD;
        end

        S_PCUPD: begin
          pc        <= w_next_pc;
          instr_cnt <= instr_cnt + 32'd1;
          r_state   <= S_FETCH;
          fetch_en  <= 1'b1;
        end

        S_HALT: begin
          r_state <= S_HALT;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_y86_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_y86_seq_ctrl
// Purpose  : Self-checking bench for y86_seq_ctrl: directed vector table,
//            hand-written halt / async-reset sequences and randomized
//            instructions checked against an instruction-level model.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_y86_seq_ctrl;

  localparam logic [63:0] RESET_PC    = 64'd0;
  localparam logic [63:0] IMEM_MAX    = 64'd1023;
  localparam int          MEM_TIMEOUT = 16;
  localparam int          N_TBL       = 13;
  localparam int          N_RAND      = 300;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  icode;
  logic        instr_valid;
  logic        imem_error;
  logic [63:0] valC;
  logic [63:0] valP;
  logic        cnd;
  logic [63:0] valM;
  logic        dmem_ack;
  logic        dmem_error;
  logic [63:0] pc;
  logic        fetch_en, decode_en, exec_en, mem_en, wb_en;
  logic        dmem_req;
  logic [2:0]  stat;
  logic        halted;
  logic [31:0] instr_cnt;
  logic [31:0] cycle_cnt;

  always #5 clk = ~clk;

  y86_seq_ctrl #(
    .RESET_PC    (RESET_PC),
    .IMEM_MAX    (IMEM_MAX),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .icode       (icode),
    .instr_valid (instr_valid),
    .imem_error  (imem_error),
    .valC        (valC),
    .valP        (valP),
    .cnd         (cnd),
    .valM        (valM),
    .dmem_ack    (dmem_ack),
    .dmem_error  (dmem_error),
    .pc          (pc),
    .fetch_en    (fetch_en),
    .decode_en   (decode_en),
    .exec_en     (exec_en),
    .mem_en      (mem_en),
    .wb_en       (wb_en),
    .dmem_req    (dmem_req),
    .stat        (stat),
    .halted      (halted),
    .instr_cnt   (instr_cnt),
    .cycle_cnt   (cycle_cnt)
  );

  typedef struct {
    logic [3:0]  icode;
    bit          valid;
    bit          ierr;
    logic [63:0] valC;
    logic [63:0] valP;
    bit          cnd;
    int          delay;     // wait cycles before ack; >= MEM_TIMEOUT means never
    bit          derr;
    logic [63:0] valM;
    logic [2:0]  exp_stat;
    logic [63:0] exp_pc;
    int          exp_cycles;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] m_pc;
  int unsigned m_icnt;
  int unsigned m_ccnt;
  vec_t        tbl[N_TBL];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_s(input string name, input string act, input string req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual=%s required=%s", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] ic, input bit va, input bit ie,
                              input logic [63:0] c, input logic [63:0] p, input bit cn,
                              input int d, input bit de, input logic [63:0] m,
                              input logic [2:0] es, input logic [63:0] ep, input int ec);
    vec_t v;
    v.icode = ic; v.valid = va; v.ierr = ie; v.valC = c; v.valP = p; v.cnd = cn;
    v.delay = d; v.derr = de; v.valM = m;
    v.exp_stat = es; v.exp_pc = ep; v.exp_cycles = ec;
    return v;
  endfunction

  // Instruction-level reference: stage trace (one letter per cycle, '-' for
  // the PC-update cycle), request cycles, final status and next PC.
  task automatic model(input vec_t v, output string tr, output int reqs,
                       output logic [2:0] st, output logic [63:0] npc, output bit stops);
    bit mem;
    tr = "FD"; reqs = 0; st = 3'd1; npc = m_pc; stops = 1'b0;
    if (v.ierr || m_pc > IMEM_MAX) begin st = 3'd3; stops = 1'b1; end
    else if (!v.valid)             begin st = 3'd4; stops = 1'b1; end
    else if (v.icode == 4'h0)      begin st = 3'd2; stops = 1'b1; end
    else begin
      tr  = {tr, "E"};
      mem = v.icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
      if (!mem) tr = {tr, "M"};
      else if (v.delay >= MEM_TIMEOUT) begin
        reqs = MEM_TIMEOUT;
        repeat (MEM_TIMEOUT) tr = {tr, "M"};
        st = 3'd3; stops = 1'b1;
      end else begin
        reqs = v.delay + 1;
        repeat (reqs) tr = {tr, "M"};
        if (v.derr) begin st = 3'd3; stops = 1'b1; end
      end
      if (!stops) begin
        tr = {tr, "W-"};
        if (v.icode == 4'h8 || (v.icode == 4'h7 && v.cnd)) npc = v.valC;
        else if (v.icode == 4'h9)                          npc = v.valM;
        else                                               npc = v.valP;
      end
    end
  endtask

  task automatic do_reset_start();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset pc", pc, RESET_PC);
    chk("reset stat", 64'(stat), 64'd1);
    chk("reset halted", 64'(halted), 64'd0);
    chk("reset instr_cnt", 64'(instr_cnt), 64'd0);
    chk("reset cycle_cnt", 64'(cycle_cnt), 64'd0);
    chk("reset strobes", 64'({fetch_en, decode_en, exec_en, mem_en, wb_en, dmem_req}), 64'd0);
    m_pc = RESET_PC; m_icnt = 0; m_ccnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start to fetch", 64'(fetch_en), 64'd1);
  endtask

  // Entered on a negedge in a FETCH cycle; returns on the negedge of the next
  // FETCH cycle or of the first HALT cycle.
  task automatic run_one(input vec_t v, input string tag, output bit stopped, output int len);
    string       mtr, tr;
    int          mreqs, reqs, cyc;
    logic [2:0]  mst;
    logic [63:0] mnpc;
    bit          mstop;
    model(v, mtr, mreqs, mst, mnpc, mstop);
    icode = v.icode; instr_valid = v.valid; imem_error = v.ierr;
    valC = v.valC; valP = v.valP; cnd = v.cnd; valM = v.valM;
    dmem_error = v.derr; dmem_ack = 1'b0;
    tr = ""; reqs = 0; cyc = 0;
    forever begin
      if ($countones({fetch_en, decode_en, exec_en, mem_en, wb_en}) > 1) tr = {tr, "X"};
      else if (fetch_en)  tr = {tr, "F"};
      else if (decode_en) tr = {tr, "D"};
      else if (exec_en)   tr = {tr, "E"};
      else if (mem_en)    tr = {tr, "M"};
      else if (wb_en)     tr = {tr, "W"};
      else                tr = {tr, "-"};
      if (dmem_req) begin
        reqs++;
        dmem_ack = (v.delay < MEM_TIMEOUT) && (reqs == v.delay + 1);
      end else begin
        dmem_ack = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (halted || fetch_en || cyc > 80) break;
    end
    dmem_ack = 1'b0;
    if (cyc > 80) begin
      n_checks++; n_fail++;
      $display("FAIL %s progress: actual=no fetch/halt in 80 cycles required=completion", tag);
    end
    if (!mstop) begin m_pc = mnpc; m_icnt++; end
    m_ccnt += mtr.len();
    chk_s({tag, " trace"}, tr, mtr);
    chk({tag, " req cycles"}, 64'(reqs), 64'(mreqs));
    chk({tag, " stat"}, 64'(stat), 64'(mst));
    chk({tag, " pc"}, pc, m_pc);
    chk({tag, " instr_cnt"}, 64'(instr_cnt), 64'(m_icnt));
    chk({tag, " cycle_cnt"}, 64'(cycle_cnt), 64'(m_ccnt));
    chk({tag, " halted"}, 64'(halted), 64'(mstop));
    stopped = halted;
    len = tr.len();
  endtask

  // Once halted, start must have no effect and nothing may move.
  task automatic halt_hold(input string tag);
    logic [2:0] st0;
    st0 = stat;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, " hold halted"}, 64'(halted), 64'd1);
    chk({tag, " hold strobes"}, 64'({fetch_en, decode_en, exec_en, mem_en, wb_en, dmem_req}), 64'd0);
    chk({tag, " hold stat"}, 64'(stat), 64'(st0));
    chk({tag, " hold pc"}, pc, m_pc);
    chk({tag, " hold cycle_cnt"}, 64'(cycle_cnt), 64'(m_ccnt));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual=simulation still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit   stopped;
    int   len, r, w;
    vec_t v;

    rst_n = 1'b0; start = 1'b0; icode = 4'h1; instr_valid = 1'b1; imem_error = 1'b0;
    valC = '0; valP = '0; cnd = 1'b0; valM = '0; dmem_ack = 1'b0; dmem_error = 1'b0;
    repeat (2) @(negedge clk);

    //           ic    va ie valC     valP     cn dly de valM      stat  pc       cyc
    tbl[0]  = mk(4'h6, 1, 0, 64'h0,   64'h2,   0, 0,  0, 64'h0,   3'd1, 64'h2,   6);
    tbl[1]  = mk(4'h7, 1, 0, 64'h40,  64'h11,  1, 0,  0, 64'h0,   3'd1, 64'h40,  6);
    tbl[2]  = mk(4'h7, 1, 0, 64'h80,  64'h9,   0, 0,  0, 64'h0,   3'd1, 64'h9,   6);
    tbl[3]  = mk(4'h9, 1, 0, 64'h0,   64'h20,  0, 3,  0, 64'h123, 3'd1, 64'h123, 9);
    tbl[4]  = mk(4'h8, 1, 0, 64'h200, 64'h30,  0, 0,  0, 64'h0,   3'd1, 64'h200, 6);
    tbl[5]  = mk(4'h5, 1, 0, 64'h0,   64'h300, 0, 99, 0, 64'h0,   3'd3, 64'h200, 19);
    tbl[6]  = mk(4'h6, 0, 0, 64'h0,   64'h2,   0, 0,  0, 64'h0,   3'd4, 64'h0,   2);
    tbl[7]  = mk(4'h0, 1, 0, 64'h0,   64'h1,   0, 0,  0, 64'h0,   3'd2, 64'h0,   2);
    tbl[8]  = mk(4'h4, 1, 0, 64'h0,   64'h8,   0, 2,  1, 64'h0,   3'd3, 64'h0,   6);
    tbl[9]  = mk(4'h6, 1, 1, 64'h0,   64'h2,   0, 0,  0, 64'h0,   3'd3, 64'h0,   2);
    tbl[10] = mk(4'h3, 1, 0, 64'h0,   64'h400, 0, 0,  0, 64'h0,   3'd1, 64'h400, 6);
    tbl[11] = mk(4'h1, 1, 0, 64'h0,   64'h401, 0, 0,  0, 64'h0,   3'd3, 64'h400, 2);
    tbl[12] = mk(4'hA, 1, 0, 64'h0,   64'h30,  0, 1,  0, 64'h0,   3'd1, 64'h30,  7);

    do_reset_start();
    for (int i = 0; i < N_TBL; i++) begin
      run_one(tbl[i], $sformatf("tbl%0d", i), stopped, len);
      chk($sformatf("tbl%0d exp stat", i), 64'(stat), 64'(tbl[i].exp_stat));
      chk($sformatf("tbl%0d exp pc", i), pc, tbl[i].exp_pc);
      chk($sformatf("tbl%0d exp cycles", i), 64'(len), 64'(tbl[i].exp_cycles));
      if (stopped) begin
        halt_hold($sformatf("tbl%0d", i));
        do_reset_start();
      end
    end

    // Asynchronous reset during a memory wait (pc is non-zero here)
    icode = 4'h5; instr_valid = 1'b1; imem_error = 1'b0; dmem_ack = 1'b0;
    w = 0;
    while (!dmem_req && w < 10) begin @(negedge clk); w++; end
    chk("async pre req", 64'(dmem_req), 64'd1);
    @(negedge clk);
    chk("async pre pc", pc, m_pc);
    #2 rst_n = 1'b0;
    #1;
    chk("async req drop", 64'(dmem_req), 64'd0);
    chk("async pc", pc, RESET_PC);
    chk("async mem_en", 64'(mem_en), 64'd0);
    chk("async instr_cnt", 64'(instr_cnt), 64'd0);
    do_reset_start();

    for (int n = 0; n < N_RAND; n++) begin
      v = mk(4'h1, 1, 0, 64'h0, 64'h0, 0, 0, 0, 64'h0, 3'd1, 64'h0, 0);
      v.icode = ($urandom_range(0, 19) == 0) ? 4'h0 : 4'($urandom_range(1, 11));
      v.valid = ($urandom_range(0, 39) != 0);
      v.ierr  = ($urandom_range(0, 49) == 0);
      v.valC  = 64'($urandom_range(0, 1100));
      v.valP  = 64'($urandom_range(0, 1040));
      v.cnd   = ($urandom_range(0, 1) == 1);
      v.valM  = 64'($urandom_range(0, 1100));
      v.derr  = ($urandom_range(0, 19) == 0);
      r = int'($urandom_range(0, 19));
      v.delay = (r < 17) ? int'($urandom_range(0, 4)) : ((r == 17) ? MEM_TIMEOUT - 1 : MEM_TIMEOUT);
      run_one(v, $sformatf("rnd%0d", n), stopped, len);
      if (stopped) begin
        halt_hold($sformatf("rnd%0d", n));
        do_reset_start();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/y86_seq_ctrl.md
Name: y86_seq_ctrl

Overview:
Multi-cycle sequencer for the sequential Y86-64 core. It owns the PC and steps one instruction at a time through the fetch, decode, execute, memory, write-back and PC-update stages by pulsing one stage enable per cycle. It waits on a req/ack handshake with data memory and computes the next PC from icode, cnd, valC, valM and valP. It also tracks processor status (AOK/HLT/ADR/INS) and stops the machine on any non-AOK status.

Parameters:
RESET_PC, 64'd0, PC value loaded on reset.
IMEM_MAX, 64'd1023, highest legal instruction byte address; PC > IMEM_MAX is an address error.
MEM_TIMEOUT, 16, cycles to wait for dmem_ack before declaring ADR.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse; leaves IDLE and begins execution at the current PC.
icode  in  4  from fetch.
instr_valid  in  1  from fetch.
imem_error  in  1  from fetch.
valC  in  64  from fetch.
valP  in  64  from fetch.
cnd  in  1  condition result from execute.
valM  in  64  memory read data, used for ret.
dmem_ack  in  1  data memory completion.
dmem_error  in  1  data memory fault, valid with dmem_ack.
pc  out  64  current instruction address.
fetch_en, decode_en, exec_en, mem_en, wb_en  out  1 each  one-hot stage strobes.
dmem_req  out  1  memory access request.
stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
halted  out  1  high in HALT state.
instr_cnt  out  32  retired instruction count.
cycle_cnt  out  32  cycles spent outside IDLE/HALT.

Behaviour:
- Reset (asynchronous, active-low): pc=RESET_PC, state=IDLE, all enables=0, dmem_req=0, stat=AOK, halted=0, both counters=0.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, PCUPD, HALT.
- IDLE -> FETCH on start. start is ignored in every other state.
- FETCH: fetch_en=1 for one cycle. Fetch outputs are sampled at the next clock edge, in DECODE.
- DECODE: decode_en=1. Error checks, in priority order:
  - imem_error or pc>IMEM_MAX -> stat=ADR, next state HALT.
  - else !instr_valid -> stat=INS, next state HALT.
  - else icode==0 -> stat=HLT, next state HALT.
  - else next state EXEC.
- EXEC: exec_en=1 for one cycle; then go to MEM.
- MEM:
  - Memory icodes are 4, 5, 8, 9, A and B. For these, hold dmem_req=1 and mem_en=1 until dmem_ack.
  - dmem_ack with dmem_error=0 -> WB.
  - dmem_ack with dmem_error=1 -> stat=ADR, HALT.
  - MEM_TIMEOUT cycles without ack -> stat=ADR, HALT.
  - dmem_req drops in the cycle after ack.
  - For non-memory icodes, MEM lasts one cycle with mem_en=1 and dmem_req=0.
- WB: wb_en=1 for one cycle.
- PCUPD: no enables. Next PC:
  - icode 8 (call), or icode 7 with cnd=1 -> valC.
  - icode 9 (ret) -> valM captured at ack.
  - otherwise -> valP.
  - instr_cnt increments, then next state FETCH.
- Instructions that stop the machine do not update pc and do not increment instr_cnt.
- HALT: halted=1 and stat is held. Only reset leaves HALT.
- cycle_cnt increments in every state except IDLE and HALT. Both counters wrap at 2^32 without a flag.
- Exactly one enable is high in any cycle, or none in IDLE, PCUPD and HALT.
- valM is captured in a 64-bit register at the ack edge. cnd is sampled at the EXEC->MEM edge.
- Reset asserted mid-operation (including during a MEM wait) aborts immediately: all outputs return to reset values and dmem_req drops asynchronously.
- pc arithmetic is 64-bit with no wrap check beyond IMEM_MAX.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants I_HALT through I_POPQ.
  - stat constants STAT_AOK, STAT_HLT, STAT_ADR, STAT_INS.
  - a state enum.
  - a function is_mem_op(icode).
- The fetch stage and this controller both import y86_pkg.
- One sub-module, y86_next_pc: a combinational next-PC mux with inputs icode, cnd, valC, valM_q, valP.

Test Plan:
- Reset then start, icode=6 (OPq), valP=2 -> stage strobes in order F,D,E,M,W over 5 cycles; pc=2 after PCUPD; instr_cnt=1; cycle_cnt=6.
- icode=7, cnd=1, valC=0x40 -> pc=0x40. Repeat with cnd=0, valP=9 -> pc=9.
- icode=9, dmem_ack after 3 wait cycles with valM=0x123 -> dmem_req high for 4 cycles (3 wait cycles plus the ack cycle); pc=0x123.
- icode=5, no ack for 16 cycles -> stat=3, halted=1, pc unchanged; then assert start -> no effect.
- instr_valid=0 -> stat=4. Separately, icode=0 -> stat=2, instr_cnt unchanged.
- Drop rst_n during MEM wait with dmem_req=1 -> dmem_req=0 and pc=RESET_PC before the next clock edge.
